line_scan_readout: RTL

LINE_SCAN_READOUT -- requirements
Module: line_scan_readout

---
 rtl/line_scan_pkg.sv | 21 ++
 rtl/adc_shift_rx.sv | 39 +++
 rtl/line_scan_readout.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/line_scan_pkg.sv
// Shared state encoding and parameter defaults for the line-scan readout block.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package line_scan_pkg;

   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_ADC_BITS   = 12;
   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_PIXELS     = 128;
   localparam int DEF_SLOT       = 36;
   localparam int DEF_INT_SLOTS  = 4;

   typedef enum logic [2:0] {
      IDLE,
      START_SLOT,
      PIXEL,
      TRAIL_SLOT,
      INTEGRATE
   } scan_state_t;

endpackage

// File: rtl/adc_shift_rx.sv
// One ADC channel: shifts in a serial frame MSB first and keeps the trailing ADC_BITS as the result.
// Latency: result updates on the clock edge that takes in the last frame bit.
// Backpressure: none; result is held until the next capture.
module adc_shift_rx
   import line_scan_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int ADC_BITS   = DEF_ADC_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                shift,
   input  logic                capture,
   input  logic                sdata,
   output logic [ADC_BITS-1:0] result
);

   logic [FRAME_BITS-1:0] frame_sr;
   logic [FRAME_BITS-1:0] frame_nxt;
   logic                  unused_oldest;

   assign frame_nxt = {frame_sr[FRAME_BITS-2:0], sdata};
   // The oldest leading bit shifts out of the frame and carries no data.
   assign unused_oldest = frame_sr[FRAME_BITS-1];

   // Shift on each sample strobe; on the final sample keep the low ADC_BITS (leading bits dropped).
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_sr <= '0;
         result   <= '0;
      end else if (shift) begin
         frame_sr <= frame_nxt;
         if (capture) begin
            result <= frame_nxt[ADC_BITS-1:0];
         end
      end
   end

endmodule

// File: rtl/line_scan_readout.sv
// Line-scan sensor clocking plus parallel serial-ADC readout, one result per channel per pixel slot.
// Latency: pix_valid at slot_cnt 2*FRAME_BITS+1 of each pixel slot; line_done on the last TRAIL_SLOT cycle.
// Backpressure: none; pix_data/pix_index hold until the next pix_valid and start while busy is ignored.
module line_scan_readout
   import line_scan_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int ADC_BITS   = DEF_ADC_BITS,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int PIXELS     = DEF_PIXELS,
   parameter int SLOT       = DEF_SLOT,
   parameter int INT_SLOTS  = DEF_INT_SLOTS,
   localparam int IDX_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
   input  logic                       clk_20M,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       continuous,
   input  logic [NUM_CH-1:0]          serial_data,
   output logic                       SI,
   output logic                       sensor_clk,
   output logic                       ADC_clk,
   output logic                       chip_select,
   output logic [NUM_CH*ADC_BITS-1:0] pix_data,
   output logic [IDX_W-1:0]           pix_index,
   output logic                       pix_valid,
   output logic                       busy,
   output logic                       line_done
);

   localparam int CNT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int PC_MAX = (PIXELS > INT_SLOTS) ? PIXELS : INT_SLOTS;
   localparam int PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(SLOT / 2);
   localparam logic [CNT_W-1:0] CNT_QUART = CNT_W'(SLOT / 4);
   localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(2 * FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_VALID = CNT_W'(2 * FRAME_BITS + 1);
   localparam logic [PC_W-1:0]  PIX_LAST  = PC_W'(PIXELS - 1);
   localparam logic [PC_W-1:0]  INT_LAST  = PC_W'((INT_SLOTS > 0) ? INT_SLOTS - 1 : 0);

   scan_state_t      state, state_nxt;
   logic [CNT_W-1:0] slot_cnt, cnt_nxt;
   logic [PC_W-1:0]  pix_cnt, pcnt_nxt;
   logic             cont_q, cont_nxt;
   logic             line_end;
   logic             si_d, sclk_d, adc_d, cs_d, pv_d, ld_d, busy_d;
   logic             frame_win;
   logic             shift_en, capture;

   // Next state and counters, then output decode from the next-state view so registered outputs align with slot_cnt.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = slot_cnt;
      pcnt_nxt  = pix_cnt;
      cont_nxt  = cont_q;
      line_end  = 1'b0;

      if (state == IDLE) begin
         if (start) begin
            state_nxt = START_SLOT;
            cnt_nxt   = '0;
            cont_nxt  = continuous;
         end
      end else if (slot_cnt != CNT_LAST) begin
         cnt_nxt = slot_cnt + 1'b1;
      end else begin
         cnt_nxt = '0;
         case (state)
            START_SLOT: begin
               state_nxt = PIXEL;
               pcnt_nxt  = '0;
            end
            PIXEL: begin
               if (pix_cnt == PIX_LAST) begin
                  state_nxt = TRAIL_SLOT;
                  pcnt_nxt  = '0;
               end else begin
                  pcnt_nxt = pix_cnt + 1'b1;
               end
            end
            TRAIL_SLOT: begin
               if (INT_SLOTS > 0) begin
                  state_nxt = INTEGRATE;
                  pcnt_nxt  = '0;
               end else begin
                  line_end = 1'b1;
               end
            end
            INTEGRATE: begin
               if (pix_cnt == INT_LAST) begin
                  line_end = 1'b1;
               end else begin
                  pcnt_nxt = pix_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // Free-run needs continuous high both at the latched line start and still now; dropping it mid-line ends after this line.
      if (line_end) begin
         if (cont_q && continuous) begin
            state_nxt = START_SLOT;
            cont_nxt  = continuous;
         end else begin
            state_nxt = IDLE;
         end
      end

      frame_win = (state_nxt == PIXEL) && (cnt_nxt != '0) && (cnt_nxt <= CNT_FRAME);
      sclk_d    = ((state_nxt == PIXEL) || (state_nxt == TRAIL_SLOT)) && (cnt_nxt < CNT_HALF);
      si_d      = ((state_nxt == START_SLOT) && (cnt_nxt >= CNT_HALF)) ||
                  ((state_nxt == PIXEL) && (pcnt_nxt == '0) && (cnt_nxt < CNT_QUART));
      cs_d      = !frame_win;
      adc_d     = !(frame_win && cnt_nxt[0]);
      pv_d      = (state_nxt == PIXEL) && (cnt_nxt == CNT_VALID);
      ld_d      = (state_nxt == TRAIL_SLOT) && (cnt_nxt == CNT_LAST);
      busy_d    = (state_nxt != IDLE);
   end

   // FSM state, slot/pixel counters and the continuous-mode latch.
   always_ff @(posedge clk_20M) begin
      if (!reset) begin
         state    <= IDLE;
         slot_cnt <= '0;
         pix_cnt  <= '0;
         cont_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         slot_cnt <= cnt_nxt;
         pix_cnt  <= pcnt_nxt;
         cont_q   <= cont_nxt;
      end
   end

   // All sensor/ADC strobes come straight from flops so they are glitch-free.
   always_ff @(posedge clk_20M) begin
      if (!reset) begin
         SI          <= 1'b0;
         sensor_clk  <= 1'b0;
         ADC_clk     <= 1'b1;
         chip_select <= 1'b1;
         pix_valid   <= 1'b0;
         line_done   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         SI          <= si_d;
         sensor_clk  <= sclk_d;
         ADC_clk     <= adc_d;
         chip_select <= cs_d;
         pix_valid   <= pv_d;
         line_done   <= ld_d;
         busy        <= busy_d;
      end
   end

   // Sample at the end of each cycle in which ADC_clk sits high after a rise (even slot_cnt 2..2*FRAME_BITS).
   assign shift_en = (state == PIXEL) && !slot_cnt[0] && (slot_cnt >= CNT_TWO) && (slot_cnt <= CNT_FRAME);
   assign capture  = shift_en && (slot_cnt == CNT_FRAME);

   // pix_index is taken together with the final sample so it matches pix_data.
   always_ff @(posedge clk_20M) begin
      if (!reset) begin
         pix_index <= '0;
      end else if (capture) begin
         pix_index <= IDX_W'(pix_cnt);
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      adc_shift_rx #(
         .FRAME_BITS (FRAME_BITS),
         .ADC_BITS   (ADC_BITS)
      ) u_rx (
         .clk     (clk_20M),
         .reset   (reset),
         .shift   (shift_en),
         .capture (capture),
         .sdata   (serial_data[ch]),
         .result  (pix_data[ch*ADC_BITS +: ADC_BITS])
      );
   end

endmodule
